// File: rtl/cl_mcl_pkg.sv
// cl_mcl_pkg: manycore-link op codes, packet types and packet layouts
package cl_mcl_pkg;

    localparam logic [7:0] OP_LOAD       = 8'd0;
    localparam logic [7:0] OP_STORE      = 8'd1;

    localparam logic [7:0] PKT_WRITE_ACK = 8'd0;
    localparam logic [7:0] PKT_READ      = 8'd1;
    localparam logic [7:0] PKT_ERROR     = 8'd2;

    typedef union packed {
        logic [31:0] data;
        logic [31:0] load_id;
    } bsg_mcl_payload_u;

    typedef struct packed {
        logic [15:0]      padding;
        logic [31:0]      addr;
        logic [7:0]       op;
        logic [7:0]       op_ex;
        bsg_mcl_payload_u payload;
        logic [7:0]       src_y_cord;
        logic [7:0]       src_x_cord;
        logic [7:0]       y_cord;
        logic [7:0]       x_cord;
    } bsg_mcl_request_s;

    typedef struct packed {
        logic [39:0] padding;
        logic [7:0]  pkt_type;
        logic [31:0] data;
        logic [31:0] load_id;
        logic [7:0]  y_cord;
        logic [7:0]  x_cord;
    } bsg_mcl_response_s;

endpackage

// File: rtl/bsg_two_fifo.sv
// bsg_two_fifo: two-entry FIFO with registered not-full flag
module bsg_two_fifo #(
    parameter int width_p = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem [2];
    logic               wptr, rptr, full, empty;
    logic               enq, deq;

    assign enq     = v_i & ~full;
    assign deq     = yumi_i & ~empty;
    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign data_o  = mem[rptr];

    // storage needs no reset; pointers and flags define what is valid
    always_ff @(posedge clk) begin
        if (enq) mem[wptr] <= data_i;
    end

    // pointers and occupancy flags; full/empty only move on a one-sided transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (enq) wptr <= ~wptr;
            if (deq) rptr <= ~rptr;
            if (enq & ~deq) begin
                empty <= 1'b0;
                full  <= ~empty;
            end else if (deq & ~enq) begin
                full  <= 1'b0;
                empty <= ~full;
            end
        end
    end

endmodule

// File: rtl/mcl_endpoint_responder.sv
// mcl_endpoint_responder: terminates manycore-link requests against a local word memory
module mcl_endpoint_responder
    import cl_mcl_pkg::*;
#(
    parameter int els_lg_p = 6
) (
    input  logic         clk_main_a0,
    input  logic         rst_main_n,
    input  logic [7:0]   my_x_i,
    input  logic [7:0]   my_y_i,
    input  logic         req_v_i,
    input  logic [127:0] req_i,
    output logic         req_ready_o,
    output logic         resp_v_o,
    output logic [127:0] resp_o,
    input  logic         resp_ready_i,
    output logic [31:0]  load_cnt_o,
    output logic [31:0]  store_cnt_o,
    output logic [31:0]  err_cnt_o
);

    bsg_mcl_request_s    req;
    bsg_mcl_response_s   resp;
    logic [31:0]         mem [2**els_lg_p];
    logic [els_lg_p-1:0] idx;
    logic                accept, err, is_load, is_store;
    logic                unused;

    assign req      = req_i;
    assign accept   = req_v_i & req_ready_o;
    assign idx      = req.addr[els_lg_p+1:2];
    assign err      = (req.x_cord != my_x_i) | (req.y_cord != my_y_i)
                    | (|(req.addr >> (els_lg_p + 2))) | (|req.addr[1:0])
                    | ((req.op != OP_LOAD) & (req.op != OP_STORE));
    assign is_load  = ~err & (req.op == OP_LOAD);
    assign is_store = ~err & (req.op == OP_STORE);
    assign unused   = ^{req.padding, req.op_ex[7:4]};

    // response is formed in the accept cycle; memory read is combinational
    always_comb begin
        resp          = '0;
        resp.x_cord   = req.src_x_cord;
        resp.y_cord   = req.src_y_cord;
        resp.pkt_type = err ? PKT_ERROR : is_load ? PKT_READ : PKT_WRITE_ACK;
        resp.data     = err ? req.addr : is_load ? mem[idx] : '0;
        resp.load_id  = (err | is_load) ? req.payload.load_id : '0;
    end

    // flop-array memory with per-byte write enables from op_ex
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            for (int i = 0; i < 2**els_lg_p; i++) mem[i] <= '0;
        end else if (accept & is_store) begin
            for (int b = 0; b < 4; b++)
                if (req.op_ex[b]) mem[idx][8*b +: 8] <= req.payload.data[8*b +: 8];
        end
    end

    // activity counters, wrapping naturally at 2^32
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            load_cnt_o  <= '0;
            store_cnt_o <= '0;
            err_cnt_o   <= '0;
        end else if (accept) begin
            load_cnt_o  <= load_cnt_o + {31'd0, is_load};
            store_cnt_o <= store_cnt_o + {31'd0, is_store};
            err_cnt_o   <= err_cnt_o + {31'd0, err};
        end
    end

    bsg_two_fifo #(.width_p(128)) u_fifo (
        .clk     (clk_main_a0),
        .rst_n   (rst_main_n),
        .v_i     (accept),
        .data_i  (resp),
        .ready_o (req_ready_o),
        .v_o     (resp_v_o),
        .data_o  (resp_o),
        .yumi_i  (resp_v_o & resp_ready_i)
    );

endmodule

// File: tb/tb_mcl_endpoint_responder.sv
// tb_mcl_endpoint_responder: directed self-checking bench for the endpoint responder
module tb_mcl_endpoint_responder;
    import cl_mcl_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   my_x = 8'd4;
    logic [7:0]   my_y = 8'd5;
    logic         req_v;
    logic [127:0] req_d;
    logic         req_ready;
    logic         resp_v;
    logic [127:0] resp_d;
    logic         resp_ready;
    logic [31:0]  load_cnt, store_cnt, err_cnt;
    bsg_mcl_response_s rsp_w;
    bsg_mcl_response_s rs;
    int errors = 0;
    int checks = 0;

    assign rsp_w = resp_d;

    always #5 clk = ~clk;

    mcl_endpoint_responder dut (
        .clk_main_a0  (clk),
        .rst_main_n   (rst_n),
        .my_x_i       (my_x),
        .my_y_i       (my_y),
        .req_v_i      (req_v),
        .req_i        (req_d),
        .req_ready_o  (req_ready),
        .resp_v_o     (resp_v),
        .resp_o       (resp_d),
        .resp_ready_i (resp_ready),
        .load_cnt_o   (load_cnt),
        .store_cnt_o  (store_cnt),
        .err_cnt_o    (err_cnt)
    );

    function automatic bsg_mcl_request_s mk(input logic [7:0] op, input logic [7:0] mask,
                                            input logic [31:0] addr, input logic [31:0] pl,
                                            input logic [7:0] x, input logic [7:0] sx,
                                            input logic [7:0] sy);
        bsg_mcl_request_s r;
        r              = '0;
        r.op           = op;
        r.op_ex        = mask;
        r.addr         = addr;
        r.payload.data = pl;
        r.x_cord       = x;
        r.y_cord       = 8'd5;
        r.src_x_cord   = sx;
        r.src_y_cord   = sy;
        return r;
    endfunction

    task automatic transact(input bsg_mcl_request_s r, output bsg_mcl_response_s o);
        int n;
        o = 'x;
        @(negedge clk);
        req_d = r;
        req_v = 1'b1;
        n = 0;
        while (!req_ready && n < 8) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_v = 1'b0;
        n = 0;
        while (!resp_v && n < 8) begin @(posedge clk); #1; n++; end
        if (resp_v) o = resp_d;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_v = 1'b0; req_d = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL reset_resp_v: got %b want 0", resp_v); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (load_cnt !== 32'd0) begin errors++; $display("FAIL reset_load_cnt: got %0d want 0", load_cnt); end
        checks++; if (store_cnt !== 32'd0) begin errors++; $display("FAIL reset_store_cnt: got %0d want 0", store_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_store_load;
        transact(mk(OP_STORE, 8'hF, 32'h10, 32'hDEADBEEF, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.pkt_type !== PKT_WRITE_ACK) begin errors++; $display("FAIL store_type: got %h want %h", rs.pkt_type, PKT_WRITE_ACK); end
        checks++; if (rs.data !== 32'd0 || rs.load_id !== 32'd0) begin errors++; $display("FAIL store_fields: got data %h id %h want 0 0", rs.data, rs.load_id); end
        transact(mk(OP_LOAD, 8'h0, 32'h10, 32'd7, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.pkt_type !== PKT_READ) begin errors++; $display("FAIL load_type: got %h want %h", rs.pkt_type, PKT_READ); end
        checks++; if (rs.data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h want deadbeef", rs.data); end
        checks++; if (rs.load_id !== 32'd7) begin errors++; $display("FAIL load_id: got %h want 7", rs.load_id); end
        checks++; if (rs.x_cord !== 8'd1 || rs.y_cord !== 8'd2) begin errors++; $display("FAIL load_dest: got %0d,%0d want 1,2", rs.x_cord, rs.y_cord); end
        checks++; if (store_cnt !== 32'd1 || load_cnt !== 32'd1) begin errors++; $display("FAIL sl_counts: got st %0d ld %0d want 1 1", store_cnt, load_cnt); end
    endtask

    task automatic test_byte_mask;
        transact(mk(OP_STORE, 8'hF, 32'h20, 32'h11223344, 8'd4, 8'd1, 8'd2), rs);
        transact(mk(OP_STORE, 8'h5, 32'h20, 32'hAABBCCDD, 8'd4, 8'd1, 8'd2), rs);
        transact(mk(OP_LOAD, 8'h0, 32'h20, 32'd1, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.data !== 32'h11BB33DD) begin errors++; $display("FAIL mask_merge: got %h want 11bb33dd", rs.data); end
        transact(mk(OP_STORE, 8'h0, 32'h20, 32'hFFFFFFFF, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.pkt_type !== PKT_WRITE_ACK) begin errors++; $display("FAIL mask0_ack: got %h want %h", rs.pkt_type, PKT_WRITE_ACK); end
        transact(mk(OP_LOAD, 8'h0, 32'h20, 32'd2, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.data !== 32'h11BB33DD) begin errors++; $display("FAIL mask0_data: got %h want 11bb33dd", rs.data); end
        checks++; if (store_cnt !== 32'd4 || load_cnt !== 32'd3) begin errors++; $display("FAIL mask_counts: got st %0d ld %0d want 4 3", store_cnt, load_cnt); end
    endtask

    task automatic test_errors;
        transact(mk(OP_STORE, 8'hF, 32'h10, 32'h12345678, 8'd9, 8'd1, 8'd2), rs);
        checks++; if (rs.pkt_type !== PKT_ERROR || rs.data !== 32'h10 || rs.load_id !== 32'h12345678) begin errors++; $display("FAIL err_x: got %h %h %h want 02 00000010 12345678", rs.pkt_type, rs.data, rs.load_id); end
        transact(mk(OP_LOAD, 8'h0, 32'h100, 32'd7, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.pkt_type !== PKT_ERROR || rs.data !== 32'h100) begin errors++; $display("FAIL err_range: got %h %h want 02 00000100", rs.pkt_type, rs.data); end
        transact(mk(8'd5, 8'h0, 32'h14, 32'hCAFE, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.pkt_type !== PKT_ERROR || rs.data !== 32'h14 || rs.load_id !== 32'hCAFE) begin errors++; $display("FAIL err_op: got %h %h %h want 02 00000014 0000cafe", rs.pkt_type, rs.data, rs.load_id); end
        transact(mk(OP_STORE, 8'hF, 32'h12, 32'h0, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.pkt_type !== PKT_ERROR || rs.data !== 32'h12) begin errors++; $display("FAIL err_align: got %h %h want 02 00000012", rs.pkt_type, rs.data); end
        checks++; if (err_cnt !== 32'd4 || store_cnt !== 32'd4 || load_cnt !== 32'd3) begin errors++; $display("FAIL err_counts: got e %0d st %0d ld %0d want 4 4 3", err_cnt, store_cnt, load_cnt); end
        transact(mk(OP_LOAD, 8'h0, 32'h10, 32'd3, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.data !== 32'hDEADBEEF) begin errors++; $display("FAIL err_mem_intact: got %h want deadbeef", rs.data); end
    endtask

    task automatic test_coords;
        transact(mk(OP_LOAD, 8'h0, 32'h20, 32'd9, 8'd4, 8'd3, 8'd9), rs);
        checks++; if (rs.x_cord !== 8'd3 || rs.y_cord !== 8'd9) begin errors++; $display("FAIL coords: got %0d,%0d want 3,9", rs.x_cord, rs.y_cord); end
        checks++; if (rs.data !== 32'h11BB33DD || load_cnt !== 32'd5) begin errors++; $display("FAIL coords_data: got %h ld %0d want 11bb33dd 5", rs.data, load_cnt); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        resp_ready = 1'b0;
        req_d = mk(OP_LOAD, 8'h0, 32'h10, 32'd1, 8'd4, 8'd1, 8'd2);
        req_v = 1'b1;
        @(negedge clk);
        checks++; if (resp_v !== 1'b1 || rsp_w.load_id !== 32'd1 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first: got v %b id %0d rdy %b want 1 1 1", resp_v, rsp_w.load_id, req_ready); end
        req_d = mk(OP_LOAD, 8'h0, 32'h10, 32'd2, 8'd4, 8'd1, 8'd2);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got rdy %b want 0", req_ready); end
        req_d = mk(OP_LOAD, 8'h0, 32'h10, 32'd3, 8'd4, 8'd1, 8'd2);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0 || rsp_w.load_id !== 32'd1) begin errors++; $display("FAIL b2b_hold: got rdy %b id %0d want 0 1", req_ready, rsp_w.load_id); end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_w.load_id !== 32'd2 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain: got id %0d rdy %b want 2 1", rsp_w.load_id, req_ready); end
        @(negedge clk);
        checks++; if (rsp_w.load_id !== 32'd3) begin errors++; $display("FAIL b2b_third: got id %0d want 3", rsp_w.load_id); end
        req_d = mk(OP_LOAD, 8'h0, 32'h10, 32'd4, 8'd4, 8'd1, 8'd2);
        for (int i = 4; i <= 7; i++) begin
            @(negedge clk);
            checks++; if (resp_v !== 1'b1 || rsp_w.load_id !== i || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_stream: got v %b id %0d rdy %b want 1 %0d 1", resp_v, rsp_w.load_id, req_ready, i); end
            if (i < 7) req_d = mk(OP_LOAD, 8'h0, 32'h10, i + 1, 8'd4, 8'd1, 8'd2);
            else req_v = 1'b0;
        end
        @(negedge clk);
        checks++; if (resp_v !== 1'b0 || load_cnt !== 32'd12) begin errors++; $display("FAIL b2b_end: got v %b ld %0d want 0 12", resp_v, load_cnt); end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_d = mk(OP_LOAD, 8'h0, 32'h10, 32'd1, 8'd4, 8'd1, 8'd2);
        req_v = 1'b1;
        @(negedge clk);
        req_d = mk(OP_LOAD, 8'h0, 32'h20, 32'd2, 8'd4, 8'd1, 8'd2);
        @(negedge clk);
        req_v = 1'b0;
        checks++; if (resp_v !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_queued: got v %b rdy %b want 1 0", resp_v, req_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (resp_v !== 1'b0) begin errors++; $display("FAIL mid_resp_v: got %b want 0", resp_v); end
        checks++; if (load_cnt !== 32'd0 || store_cnt !== 32'd0 || err_cnt !== 32'd0) begin errors++; $display("FAIL mid_counts: got %0d %0d %0d want 0 0 0", load_cnt, store_cnt, err_cnt); end
        @(negedge clk) rst_n = 1'b1;
        transact(mk(OP_LOAD, 8'h0, 32'h10, 32'd5, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.pkt_type !== PKT_READ || rs.data !== 32'd0) begin errors++; $display("FAIL mid_mem10: got %h %h want 01 00000000", rs.pkt_type, rs.data); end
        transact(mk(OP_LOAD, 8'h0, 32'h20, 32'd6, 8'd4, 8'd1, 8'd2), rs);
        checks++; if (rs.data !== 32'd0 || load_cnt !== 32'd2) begin errors++; $display("FAIL mid_mem20: got %h ld %0d want 0 2", rs.data, load_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_store_load;
        test_byte_mask;
        test_errors;
        test_coords;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
